// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if : byte-stream input and instruction-memory write bus of the
// program loader, bundled with its status outputs.
//
// Parameter
//   ADDR_W      instruction-memory word-address width
// Signals
//   in_valid    byte-stream valid              (source -> loader)
//   in_data     byte-stream data, 8 bits       (source -> loader)
//   in_ready    loader can take a byte         (loader -> source)
//   imem_wren   one-cycle write strobe per assembled word
//   imem_addr   word address of the current write
//   imem_wdata  assembled 32-bit instruction word
//   cpu_hold    keep the CPU in reset
//   busy        loader is inside a frame
//   done        one-cycle pulse, frame accepted
//   err         one-cycle pulse, frame rejected
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready
// are both 1. The source holds in_data stable while in_valid is 1 and may drop
// in_valid at any time; in_ready does not depend on in_valid.
//
// Modports: master = byte source / memory observer, slave = the loader.
// ---------------------------------------------------------------------------
interface prog_loader_if #(
  parameter int ADDR_W = 11
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_wren, imem_addr, imem_wdata,
    input  cpu_hold, busy, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_wren, imem_addr, imem_wdata,
    output cpu_hold, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader : receives a framed byte stream and writes it into instruction
// memory, holding the CPU in reset while a program is loading.
//
// Frame: SYNC_BYTE, count lo, count hi (N words), 4N payload bytes with each
// word little-endian (first byte = bits 7:0), then an optional checksum byte.
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to add the CHK state, which
// takes one extra byte and compares it with the XOR of all payload bytes.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   lp           prog_loader_if.slave (byte stream in, imem writes/status out)
//   dbg_state_o  current FSM state (IDLE=0, LEN_LO=1, LEN_HI=2, DATA=3, CHK=4)
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int          ADDR_W    = 11,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  prog_loader_if.slave       lp,
  output logic [2:0]         dbg_state_o
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3
  } state_t;
`endif

  // Largest legal word count is the full memory depth.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t            state_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       rem_q;        // words still to be written in this frame
  logic [ADDR_W:0]   idx_q;        // one spare bit so the index never wraps
  logic [1:0]        bcnt_q;       // byte position inside the current word
  logic [31:0]       asm_q;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  logic [31:0] asm_d;
  logic [15:0] len_d;

  // New bytes enter at the top so the first byte ends up in bits 7:0.
  assign asm_d = {lp.in_data, asm_q[31:8]};
  assign len_d = {lp.in_data, len_lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      asm_q    <= '0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      wren_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // in_ready is 1 whenever rst is low, so in_valid alone means accept.
      if (lp.in_valid) begin
        case (state_q)
          IDLE: begin
            if (lp.in_data == SYNC_BYTE) begin
              state_q <= LEN_LO;
              hold_q  <= 1'b1;
              idx_q   <= '0;
              bcnt_q  <= '0;
              asm_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
              chk_q   <= '0;
`endif
            end
          end
          LEN_LO: begin
            len_lo_q <= lp.in_data;
            state_q  <= LEN_HI;
          end
          LEN_HI: begin
            rem_q <= len_d;
            if ({1'b0, len_d} > MAX_WORDS) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else if (len_d == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_q <= CHK;
`else
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
              state_q <= IDLE;
`endif
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            asm_q  <= asm_d;
            bcnt_q <= bcnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q  <= chk_q ^ lp.in_data;
`endif
            if (bcnt_q == 2'd3) begin
              wren_q  <= 1'b1;
              wdata_q <= asm_d;
              addr_q  <= idx_q[ADDR_W-1:0];
              idx_q   <= idx_q + 1'b1;
              rem_q   <= rem_q - 16'd1;
              if (rem_q == 16'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_q <= CHK;
`else
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
                state_q <= IDLE;
`endif
              end
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          CHK: begin
            // A bad checksum leaves hold_q at 1 so the CPU stays in reset.
            if (lp.in_data == chk_q) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              err_q  <= 1'b1;
            end
            state_q <= IDLE;
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign lp.in_ready   = ~rst;
  assign lp.imem_wren  = wren_q;
  assign lp.imem_addr  = addr_q;
  assign lp.imem_wdata = wdata_q;
  assign lp.cpu_hold   = hold_q;
  assign lp.busy       = (state_q != IDLE);
  assign lp.done       = done_q;
  assign lp.err        = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader : scoreboard bench for prog_loader. Two instances share the
// clock and reset: dut_a with the default ADDR_W=11, dut_b with ADDR_W=4 for
// the word-count limit. Expected writes/done/err events are queued as each
// frame is issued; a negedge monitor pops and compares every event the DUTs
// produce. Builds with or without PROG_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  localparam int W = 52;  // {dut, type[1:0], hold, addr[15:0], data[31:0]}
  localparam logic [1:0] T_WR = 2'd1, T_DONE = 2'd2, T_ERR = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] dbg_a, dbg_b;

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  prog_loader_if #(.ADDR_W(11)) a_if ();
  prog_loader_if #(.ADDR_W(4))  b_if ();

  prog_loader #(.ADDR_W(11), .SYNC_BYTE(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .lp(a_if), .dbg_state_o(dbg_a)
  );
  prog_loader #(.ADDR_W(4), .SYNC_BYTE(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .lp(b_if), .dbg_state_o(dbg_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d events still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input bit dut, input logic [1:0] t, input logic hold,
                                      input logic [15:0] addr, input logic [31:0] data);
    return {dut, t, hold, addr, data};
  endfunction

  function automatic logic [7:0] xor_payload(input logic [7:0] f[$]);
    logic [7:0] x = 8'h00;
    for (int i = 3; i < f.size(); i++) x ^= f[i];
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_ev(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got event %h, expected no event", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got event %h, expected %h", name, act, e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.imem_wren) check_ev("a_write", ev(1'b0, T_WR, 1'b0, 16'(a_if.imem_addr), a_if.imem_wdata));
      if (a_if.done)      check_ev("a_done",  ev(1'b0, T_DONE, a_if.cpu_hold, 16'h0, 32'h0));
      if (a_if.err)       check_ev("a_err",   ev(1'b0, T_ERR,  a_if.cpu_hold, 16'h0, 32'h0));
      if (b_if.imem_wren) check_ev("b_write", ev(1'b1, T_WR, 1'b0, 16'(b_if.imem_addr), b_if.imem_wdata));
      if (b_if.done)      check_ev("b_done",  ev(1'b1, T_DONE, b_if.cpu_hold, 16'h0, 32'h0));
      if (b_if.err)       check_ev("b_err",   ev(1'b1, T_ERR,  b_if.cpu_hold, 16'h0, 32'h0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin b_if.in_valid = v; b_if.in_data = d; end
    else     begin a_if.in_valid = v; a_if.in_data = d; end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    @(negedge clk);
    drive(sel, 1'b1, b);
    repeat (gap) begin
      @(negedge clk);
      drive(sel, 1'b0, 8'h00);
    end
  endtask

  task automatic end_stream(input bit sel);
    @(negedge clk);
    drive(sel, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] f[$], input int gap);
    foreach (f[i]) send_byte(sel, f[i], gap);
    end_stream(sel);
  endtask

  task automatic push_wr(input bit sel, input logic [15:0] addr, input logic [31:0] data);
    exp_q.push_back(ev(sel, T_WR, 1'b0, addr, data));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] f[$];
  logic [7:0] fb[$];

  initial begin
    a_if.in_valid = 1'b0; a_if.in_data = 8'h00;
    b_if.in_valid = 1'b0; b_if.in_data = 8'h00;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state",    32'(dbg_a), 32'd0);
    check("rst_cpu_hold", 32'(a_if.cpu_hold), 32'd1);
    check("rst_busy",     32'(a_if.busy), 32'd0);
    check("rst_wren",     32'(a_if.imem_wren), 32'd0);
    check("rst_addr",     32'(a_if.imem_addr), 32'd0);
    check("rst_wdata",    a_if.imem_wdata, 32'd0);
    check("rst_done_err", 32'({a_if.done, a_if.err}), 32'd0);
    check("rst_in_ready", 32'(a_if.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(a_if.in_ready), 32'd1);

    // non-sync bytes in IDLE are dropped
    send_byte(1'b0, 8'h00, 0);
    end_stream(1'b0);
    check("idle_00_busy", 32'(a_if.busy), 32'd0);
    send_byte(1'b0, 8'h13, 0);
    end_stream(1'b0);
    check("idle_13_busy", 32'(a_if.busy), 32'd0);
    check("idle_cpu_hold", 32'(a_if.cpu_hold), 32'd1);

    // two-word frame, back-to-back bytes
    f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3, 8'h0A, 8'h10, 8'hA0, 8'hE3};
`ifdef PROG_LOADER_CHECKSUM_EN
    f.push_back(xor_payload(f));
`endif
    push_wr(1'b0, 16'd0, 32'hE3A00001);
    push_wr(1'b0, 16'd1, 32'hE3A0100A);
    exp_q.push_back(ev(1'b0, T_DONE, 1'b0, 16'h0, 32'h0));
    send_frame(1'b0, f, 0);
    wait_drain("frame_drain");
    check("frame_cpu_hold", 32'(a_if.cpu_hold), 32'd0);
    check("frame_busy", 32'(a_if.busy), 32'd0);

    // same frame with 3 idle cycles between bytes
    push_wr(1'b0, 16'd0, 32'hE3A00001);
    push_wr(1'b0, 16'd1, 32'hE3A0100A);
    exp_q.push_back(ev(1'b0, T_DONE, 1'b0, 16'h0, 32'h0));
    send_frame(1'b0, f, 3);
    wait_drain("gap_drain");
    check("gap_cpu_hold", 32'(a_if.cpu_hold), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // wrong checksum: words still written, err, CPU stays held
    f[f.size()-1] = 8'h05;
    push_wr(1'b0, 16'd0, 32'hE3A00001);
    push_wr(1'b0, 16'd1, 32'hE3A0100A);
    exp_q.push_back(ev(1'b0, T_ERR, 1'b1, 16'h0, 32'h0));
    send_frame(1'b0, f, 0);
    wait_drain("badchk_drain");
    check("badchk_cpu_hold", 32'(a_if.cpu_hold), 32'd1);
    f[f.size()-1] = xor_payload(f[0:f.size()-2]);
    push_wr(1'b0, 16'd0, 32'hE3A00001);
    push_wr(1'b0, 16'd1, 32'hE3A0100A);
    exp_q.push_back(ev(1'b0, T_DONE, 1'b0, 16'h0, 32'h0));
    send_frame(1'b0, f, 0);
    wait_drain("goodchk_drain");
    check("goodchk_cpu_hold", 32'(a_if.cpu_hold), 32'd0);
`endif

    // sync byte inside payload is plain data
    f = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
`ifdef PROG_LOADER_CHECKSUM_EN
    f.push_back(xor_payload(f));
`endif
    push_wr(1'b0, 16'd0, 32'hA5A5A5A5);
    exp_q.push_back(ev(1'b0, T_DONE, 1'b0, 16'h0, 32'h0));
    send_frame(1'b0, f, 1);
    wait_drain("sync_data_drain");

    // ADDR_W=4: 17 words is one too many
    fb = '{8'hA5, 8'h11, 8'h00};
    exp_q.push_back(ev(1'b1, T_ERR, 1'b1, 16'h0, 32'h0));
    send_frame(1'b1, fb, 0);
    wait_drain("b_over_drain");
    check("b_over_state", 32'(dbg_b), 32'd0);
    check("b_over_cpu_hold", 32'(b_if.cpu_hold), 32'd1);

    // zero-word frame
    fb = '{8'hA5, 8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    fb.push_back(8'h00);
`endif
    exp_q.push_back(ev(1'b1, T_DONE, 1'b0, 16'h0, 32'h0));
    send_frame(1'b1, fb, 0);
    wait_drain("b_zero_drain");
    check("b_zero_cpu_hold", 32'(b_if.cpu_hold), 32'd0);

    // exactly 16 words fills the 4-bit address space, addresses 0..15
    fb = '{8'hA5, 8'h10, 8'h00};
    for (int k = 0; k < 64; k++) fb.push_back(8'(k * 3 + 8'h11));
    for (int w = 0; w < 16; w++)
      push_wr(1'b1, 16'(w), {fb[3+4*w+3], fb[3+4*w+2], fb[3+4*w+1], fb[3+4*w]});
`ifdef PROG_LOADER_CHECKSUM_EN
    fb.push_back(xor_payload(fb));
`endif
    exp_q.push_back(ev(1'b1, T_DONE, 1'b0, 16'h0, 32'h0));
    send_frame(1'b1, fb, 0);
    wait_drain("b_full_drain");

    // reset after the 6th byte of a two-word frame: nothing written yet
    f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'hA0};
    send_frame(1'b0, f, 0);
    check("mid_busy", 32'(a_if.busy), 32'd1);
    check("mid_state", 32'(dbg_a), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(dbg_a), 32'd0);
    check("mid_rst_cpu_hold", 32'(a_if.cpu_hold), 32'd1);
    check("mid_rst_busy", 32'(a_if.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_state", 32'(dbg_a), 32'd0);

    // a complete frame after the abandoned one starts again at word 0
    f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3, 8'h0A, 8'h10, 8'hA0, 8'hE3};
`ifdef PROG_LOADER_CHECKSUM_EN
    f.push_back(xor_payload(f));
`endif
    push_wr(1'b0, 16'd0, 32'hE3A00001);
    push_wr(1'b0, 16'd1, 32'hE3A0100A);
    exp_q.push_back(ev(1'b0, T_DONE, 1'b0, 16'h0, 32'h0));
    send_frame(1'b0, f, 0);
    wait_drain("recover_drain");
    check("recover_cpu_hold", 32'(a_if.cpu_hold), 32'd0);

    // quiet period to catch stray events
    repeat (10) @(negedge clk);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
